// File: rtl/lcd_cmd_pkg.sv
// lcd_cmd_pkg: shared FSM states, HD44780 command codes and the power-on init table.
package lcd_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      HOLD,
      NIB_GAP,
      EXEC_WAIT,
      INIT_WAIT
   } state_t;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   // Init waits in ACLK cycles at 100 MHz: 40 ms, 4.1 ms, 100 us.
   localparam int INIT_PWR_CYC = 4_000_000;
   localparam int INIT_W1_CYC  = 410_000;
   localparam int INIT_W2_CYC  = 10_000;
   localparam logic [3:0] INIT_LAST_STEP = 4'd9;

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Steps 1..4 are single nibbles, steps 5..8 full command bytes.
   function automatic logic [3:0] init_nib(input logic [3:0] s);
      return (s == 4'd4) ? 4'h2 : 4'h3;
   endfunction

   function automatic int init_nib_wait(input logic [3:0] s, input int exec_cyc);
      return (s == 4'd1) ? INIT_W1_CYC : (s == 4'd4) ? exec_cyc : INIT_W2_CYC;
   endfunction

   function automatic logic [7:0] init_byte(input logic [3:0] s);
      return (s == 4'd5) ? 8'h28 : (s == 4'd6) ? 8'h0C : (s == 4'd7) ? 8'h06 : CMD_CLEAR;
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous FIFO of {rs, data} entries with full/empty/level status.
module lcd_cmd_fifo
   import lcd_cmd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 9
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge ACLK) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine: FIFO-fed HD44780 4-bit bus serialiser with strobe, setup/hold and exec-wait timing.
// Define LCD_INIT_SEQ_EN to run the power-on init sequence in hardware after reset.
module lcd_cmd_engine
   import lcd_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SETUP_CYC   = 8,
   parameter int EN_HIGH_CYC = 50,
   parameter int HOLD_CYC    = 2,
   parameter int NIB_GAP_CYC = 100,
   parameter int EXEC_CYC    = 4000,
   parameter int LONG_CYC    = 164000
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic                          wr_rs,
   input  logic [7:0]                    wr_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          init_done,
   output logic                          lcd_rs,
   output logic                          lcd_rw,
   output logic                          lcd_en,
   output logic [3:0]                    lcd_d
);

   localparam int MAXT = maxi(maxi(maxi(LONG_CYC, EXEC_CYC), maxi(NIB_GAP_CYC, EN_HIGH_CYC)),
                              maxi(SETUP_CYC, HOLD_CYC));
`ifdef LCD_INIT_SEQ_EN
   localparam int MAXW = maxi(MAXT, INIT_PWR_CYC);
`else
   localparam int MAXW = MAXT;
`endif
   localparam int CW = $clog2(MAXW + 1);

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d, wait_q, wait_d;
   logic [3:0]    low_nib, low_nib_d, lcd_d_d;
   logic          lo, lo_d, single, single_d, lcd_rs_d, done_d;
   logic          push, pop, full, empty, ld, ld_rs;
   logic [7:0]    ld_byte;
   logic [8:0]    rdata;
`ifdef LCD_INIT_SEQ_EN
   logic [3:0]    step, step_d;
`endif

   assign wr_ready = !full;
   assign push     = wr_valid && wr_ready;
   assign busy     = state != IDLE;
   assign lcd_rw   = 1'b0;

   lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .push    (push),
      .pop     (pop),
      .wdata   ({wr_rs, wr_data}),
      .rdata   (rdata),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d   = state;
      cnt_d     = (cnt != '0) ? cnt - 1'b1 : cnt;
      wait_d    = wait_q;
      low_nib_d = low_nib;
      lo_d      = lo;
      single_d  = single;
      lcd_rs_d  = lcd_rs;
      lcd_d_d   = lcd_d;
      pop       = 1'b0;
      ld        = 1'b0;
      ld_rs     = rdata[8];
      ld_byte   = rdata[7:0];
`ifdef LCD_INIT_SEQ_EN
      done_d    = init_done;
      step_d    = step;
`else
      done_d    = 1'b1;
`endif
      case (state)
         IDLE: begin
`ifdef LCD_INIT_SEQ_EN
            if (!init_done) begin
               step_d = step + 4'd1;
               if (step == 4'd0) begin
                  state_d = INIT_WAIT;
                  cnt_d   = CW'(INIT_PWR_CYC - 1);
               end else if (step <= 4'd4) begin
                  state_d  = SETUP;
                  cnt_d    = CW'(SETUP_CYC - 1);
                  single_d = 1'b1;
                  lo_d     = 1'b0;
                  lcd_rs_d = 1'b0;
                  lcd_d_d  = init_nib(step);
                  wait_d   = CW'(init_nib_wait(step, EXEC_CYC) - 1);
               end else begin
                  ld      = 1'b1;
                  ld_rs   = 1'b0;
                  ld_byte = init_byte(step);
               end
            end else
`endif
            if (init_done && !empty) begin
               pop = 1'b1;
               ld  = 1'b1;
            end
            if (ld) begin
               state_d   = SETUP;
               cnt_d     = CW'(SETUP_CYC - 1);
               single_d  = 1'b0;
               lo_d      = 1'b0;
               lcd_rs_d  = ld_rs;
               lcd_d_d   = ld_byte[7:4];
               low_nib_d = ld_byte[3:0];
               wait_d    = (!ld_rs && (ld_byte == CMD_CLEAR || ld_byte == CMD_HOME)) ?
                           CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
            end
         end
         SETUP: if (cnt == '0) begin
            state_d = EN_HI;
            cnt_d   = CW'(EN_HIGH_CYC - 1);
         end
         EN_HI: if (cnt == '0) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYC - 1);
         end
         HOLD: if (cnt == '0) begin
            state_d = (lo || single) ? EXEC_WAIT : NIB_GAP;
            cnt_d   = (lo || single) ? wait_q : CW'(NIB_GAP_CYC - 1);
         end
         NIB_GAP: if (cnt == '0) begin
            state_d = SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
            lo_d    = 1'b1;
            lcd_d_d = low_nib;
         end
         EXEC_WAIT: if (cnt == '0) begin
            state_d = IDLE;
`ifdef LCD_INIT_SEQ_EN
            if (!init_done && step == INIT_LAST_STEP) done_d = 1'b1;
`endif
         end
         INIT_WAIT: if (cnt == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // lcd_en is registered off the next state so it is glitch-free and drops on reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= IDLE;
         cnt       <= '0;
         wait_q    <= '0;
         low_nib   <= '0;
         lo        <= 1'b0;
         single    <= 1'b0;
         init_done <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_d     <= '0;
`ifdef LCD_INIT_SEQ_EN
         step      <= '0;
`endif
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         wait_q    <= wait_d;
         low_nib   <= low_nib_d;
         lo        <= lo_d;
         single    <= single_d;
         init_done <= done_d;
         lcd_en    <= state_d == EN_HI;
         lcd_rs    <= lcd_rs_d;
         lcd_d     <= lcd_d_d;
`ifdef LCD_INIT_SEQ_EN
         step      <= step_d;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// tb_lcd_cmd_engine: randomized self-checking bench; a bus monitor rebuilds bytes from E strobes.
`timescale 1ns/1ps
module tb_lcd_cmd_engine;

   localparam int SETUP = 2, EN_HIGH = 4, HOLD = 1, GAP = 3, EXEC = 10, LONG = 40, DEPTH = 8;

   logic       ACLK = 1'b0, ARESETN = 1'b0, wr_valid = 1'b0, wr_rs = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_ready, busy, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [3:0] lcd_d, fifo_level;

   int         checks = 0, failures = 0;
   logic [4:0] nib_q [$];
   logic [8:0] exp_q [$];
   bit         mon_on = 1'b0;
   int         en_cnt = 0, since = 0;
   logic [4:0] cap, prev_bus;
   bit         stable, setup_ok;

   lcd_cmd_engine #(
      .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .EN_HIGH_CYC(EN_HIGH), .HOLD_CYC(HOLD),
      .NIB_GAP_CYC(GAP), .EXEC_CYC(EXEC), .LONG_CYC(LONG)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_rs(wr_rs), .wr_data(wr_data), .busy(busy), .fifo_level(fifo_level),
      .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_d(lcd_d)
   );

   always #5 ACLK = ~ACLK;

   function automatic int busy_model(input logic rs, input logic [7:0] b);
      return 2 * (SETUP + EN_HIGH + HOLD) + GAP + ((!rs && (b == 8'h01 || b == 8'h02)) ? LONG : EXEC);
   endfunction

   // Each E pulse must last EN_HIGH cycles, keep RS/D stable and follow SETUP cycles of stable data.
   always @(negedge ACLK) begin
      if (!mon_on || !ARESETN) begin
         en_cnt = 0;
         since  = 0;
      end else if (lcd_en) begin
         if (en_cnt == 0) begin
            cap      = {lcd_rs, lcd_d};
            stable   = 1'b1;
            setup_ok = since + 1 >= SETUP;
         end else if ({lcd_rs, lcd_d} !== cap) stable = 1'b0;
         en_cnt++;
      end else begin
         if (en_cnt != 0) begin
            checks++;
            if (en_cnt != EN_HIGH || !stable || !setup_ok) begin
               failures++;
               $display("FAIL strobe: nibble=%h en_cycles=%0d stable=%0b setup_ok=%0b, required en_cycles=%0d stable=1 setup_ok=1",
                        cap, en_cnt, stable, setup_ok, EN_HIGH);
            end
            nib_q.push_back(cap);
         end
         en_cnt = 0;
         since  = ({lcd_rs, lcd_d} === prev_bus) ? since + 1 : 0;
      end
      prev_bus = {lcd_rs, lcd_d};
   end

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge ACLK);
         ok = !busy && fifo_level == 0;
      end
   endtask

   task automatic test_reset;
      ARESETN = 1'b0;
      #12;
      checks++;
      if ({wr_ready, busy, fifo_level, init_done} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_status: ready/busy/level/init=%b, required 1/0/0000/0", {wr_ready, busy, fifo_level, init_done});
      end
      checks++;
      if ({lcd_en, lcd_rs, lcd_rw, lcd_d} !== 7'd0) begin
         failures++;
         $display("FAIL reset_lcd_bus: en/rs/rw/d=%b, required 0000000", {lcd_en, lcd_rs, lcd_rw, lcd_d});
      end
      @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);
      checks++;
      if ({init_done, busy} !== 2'b10) begin
         failures++;
         $display("FAIL post_reset: init_done/busy=%b, required 10", {init_done, busy});
      end
      mon_on = 1'b1;
   endtask

   task automatic test_byte_timing;
      logic [8:0] vec [7] = '{9'h141, 9'h001, 9'h002, 9'h101, 9'h102, 9'h003, 9'h000};
      logic [8:0] v;
      int n, t;
      for (int k = 0; k < 11; k++) begin
         v = (k < 7) ? vec[k] : 9'($urandom_range(0, 511));
         exp_q.delete();
         nib_q.delete();
         @(negedge ACLK);
         wr_valid = 1'b1;
         wr_rs    = v[8];
         wr_data  = v[7:0];
         @(negedge ACLK);
         wr_valid = 1'b0;
         for (t = 0; t < 20 && !busy; t++) @(negedge ACLK);
         n = 0;
         while (busy && n < 1000) begin
            n++;
            @(negedge ACLK);
         end
         checks++;
         if (n != busy_model(v[8], v[7:0])) begin
            failures++;
            $display("FAIL busy_len rs=%0b byte=%h: got %0d cycles, required %0d", v[8], v[7:0], n, busy_model(v[8], v[7:0]));
         end
         checks++;
         if (nib_q.size() != 2 || {nib_q[0], nib_q[1]} !== {v[8], v[7:4], v[8], v[3:0]}) begin
            failures++;
            $display("FAIL nibbles byte=%h: got %0d nibbles, required {rs,d}=%h %h",
                     v[7:0], nib_q.size(), {v[8], v[7:4]}, {v[8], v[3:0]});
         end
         checks++;
         if (fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL level_after_byte: got %0d, required 0", fifo_level);
         end
      end
   endtask

   task automatic compare_stream(input string tag);
      checks++;
      if (nib_q.size() != 2 * exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d nibbles, required %0d", tag, nib_q.size(), 2 * exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({nib_q[2*i], nib_q[2*i+1]} !== {exp_q[i][8], exp_q[i][7:4], exp_q[i][8], exp_q[i][3:0]}) begin
               failures++;
               $display("FAIL %s_byte%0d: got %h %h, required rs/byte %b/%h", tag, i, nib_q[2*i], nib_q[2*i+1], exp_q[i][8], exp_q[i][7:0]);
            end
         end
      end
   endtask

   task automatic test_fill;
      logic [8:0] v;
      bit acc, ok;
      int t;
      exp_q.delete();
      nib_q.delete();
      @(negedge ACLK);
      v = 9'($urandom_range(0, 511));
      wr_valid = 1'b1;
      {wr_rs, wr_data} = v;
      exp_q.push_back(v);
      @(negedge ACLK);
      wr_valid = 1'b0;
      for (t = 0; t < 20 && !busy; t++) @(negedge ACLK);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            checks++;
            if ({wr_ready, fifo_level} !== {1'b0, 4'd8}) begin
               failures++;
               $display("FAIL fifo_full: ready/level=%b/%0d, required 0/8", wr_ready, fifo_level);
            end
         end
         v = 9'($urandom_range(0, 511));
         wr_valid = 1'b1;
         {wr_rs, wr_data} = v;
         acc = wr_ready;
         if (acc) exp_q.push_back(v);
         checks++;
         if (acc !== (i < 8)) begin
            failures++;
            $display("FAIL fill_accept%0d: got %0b, required %0b", i, acc, i < 8);
         end
         @(negedge ACLK);
      end
      wr_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL fill_drain: engine not idle within bound, level=%0d", fifo_level);
      end
      compare_stream("fill");
   endtask

   task automatic test_push_on_pop;
      logic [8:0] v;
      bit ok;
      int t;
      exp_q.delete();
      nib_q.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         v = 9'($urandom_range(0, 511));
         wr_valid = 1'b1;
         {wr_rs, wr_data} = v;
         exp_q.push_back(v);
      end
      @(negedge ACLK);
      wr_valid = 1'b0;
      checks++;
      if (fifo_level !== 4'd3 || !busy) begin
         failures++;
         $display("FAIL pop_setup: level/busy=%0d/%0b, required 3/1", fifo_level, busy);
      end
      for (t = 0; t < 200 && busy; t++) @(negedge ACLK);
      v = 9'($urandom_range(0, 511));
      wr_valid = 1'b1;
      {wr_rs, wr_data} = v;
      exp_q.push_back(v);
      @(negedge ACLK);
      wr_valid = 1'b0;
      checks++;
      if (fifo_level !== 4'd3 || !busy) begin
         failures++;
         $display("FAIL push_on_pop: level/busy=%0d/%0b, required 3/1", fifo_level, busy);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL pop_drain: engine not idle within bound, level=%0d", fifo_level);
      end
      compare_stream("pushpop");
   endtask

   task automatic test_reset_mid;
      logic [8:0] v;
      bit ok;
      int t;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         wr_valid = 1'b1;
         {wr_rs, wr_data} = 9'($urandom_range(0, 511));
      end
      @(negedge ACLK);
      wr_valid = 1'b0;
      for (t = 0; t < 100 && !lcd_en; t++) @(negedge ACLK);
      checks++;
      if (!lcd_en) begin
         failures++;
         $display("FAIL mid_en_seen: lcd_en=%0b, required 1", lcd_en);
      end
      mon_on = 1'b0;
      #1 ARESETN = 1'b0;
      #1;
      checks++;
      if ({lcd_en, busy, fifo_level, wr_ready} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset: en/busy/level/ready=%b, required 0/0/0000/1", {lcd_en, busy, fifo_level, wr_ready});
      end
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      nib_q.delete();
      exp_q.delete();
      mon_on = 1'b1;
      @(negedge ACLK);
      v = 9'($urandom_range(0, 511));
      wr_valid = 1'b1;
      {wr_rs, wr_data} = v;
      exp_q.push_back(v);
      @(negedge ACLK);
      wr_valid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL reset_drain: engine not idle within bound, level=%0d", fifo_level);
      end
      compare_stream("after_reset");
   endtask

   initial begin
      test_reset;
      test_byte_timing;
      test_fill;
      test_push_on_pop;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_engine.md
Name: lcd_cmd_engine

Overview:
- Downstream stage of the myip_lcd AXI4-Lite register slave.
- Accepts command/data bytes pushed by the register file, buffers them in a small FIFO, and serialises each byte onto an HD44780-compatible 4-bit parallel LCD bus.
- Generates E-strobe, setup/hold and execution-wait timing.
- Exposes busy and FIFO-level status for read-back through the register file.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- SETUP_CYC, 8, ACLK cycles RS/D are stable before E rises.
- EN_HIGH_CYC, 50, ACLK cycles E stays high.
- HOLD_CYC, 2, ACLK cycles RS/D are held after E falls.
- NIB_GAP_CYC, 100, idle cycles between the high and low nibble.
- EXEC_CYC, 4000, post-byte wait for normal commands and data.
- LONG_CYC, 164000, post-byte wait for clear (0x01) and home (0x02) commands.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- wr_valid  in  1  push request from the register file.
- wr_ready  out  1  FIFO can accept.
- wr_rs  in  1  0 = command, 1 = data.
- wr_data  in  8  byte to send.
- busy  out  1  byte transfer or exec wait in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- init_done  out  1  LCD ready for user traffic.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; constant 0 (write only).
- lcd_en  out  1  LCD enable strobe.
- lcd_d  out  4  LCD data nibble D7..D4.

Behaviour:
- Clock and reset: one clock, ACLK; reset is asynchronous and active-low, ARESETN.
- Reset values: all outputs 0 except wr_ready = 1. FIFO empty, FSM in IDLE.
- Reset mid-operation: lcd_en drops immediately; the in-flight byte and FIFO contents are discarded.
- Push: a push occurs when wr_valid && wr_ready.
- wr_ready = !full. It is registered-state based; no combinational path from the pop.
- When full, a push is blocked even in a cycle where a pop occurs.
- Simultaneous push and pop when not full: fifo_level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, EN_HI, HOLD, NIB_GAP, EXEC_WAIT (plus INIT states when the optional feature is enabled).
- IDLE: when init_done && !empty, pop, latch rs/byte, drive lcd_rs and lcd_d = byte[7:4], go to SETUP.
- busy rises the cycle after the pop.
- SETUP: SETUP_CYC cycles with lcd_en = 0, then EN_HI.
- EN_HI: lcd_en = 1 for EN_HIGH_CYC cycles, then HOLD.
- HOLD: lcd_en = 0 for HOLD_CYC cycles. After the high nibble go to NIB_GAP; after the low nibble go to EXEC_WAIT.
- NIB_GAP: NIB_GAP_CYC cycles, then lcd_d = byte[3:0], go to SETUP.
- EXEC_WAIT: wait LONG_CYC if rs = 0 and byte is 0x01 or 0x02, otherwise EXEC_CYC; then go to IDLE and drop busy in the same cycle.
- Per-byte busy duration: 2*(SETUP_CYC+EN_HIGH_CYC+HOLD_CYC) + NIB_GAP_CYC + wait.
- A back-to-back byte is popped on the first IDLE cycle.
- Single down-counter sized to $clog2(max(LONG_CYC, init waits)+1). It loads count-1 on state entry; the state exits at 0.
- lcd_d and lcd_rs change only in IDLE and at the NIB_GAP exit, never while lcd_en = 1.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Defined: after reset the FSM runs the power-on init, with init_done = 0 throughout and FIFO pushes still accepted.
- Init sequence:
  - wait 40 ms (4,000,000 cycles);
  - nibble 0x3, wait 4.1 ms;
  - nibble 0x3, wait 100 us;
  - nibble 0x3, wait 100 us;
  - nibble 0x2, wait EXEC_CYC;
  - then full bytes 0x28, 0x0C, 0x06, 0x01, each with normal command timing.
- Each init nibble uses the SETUP/EN_HI/HOLD timing with rs = 0.
- init_done rises when the init sequence's final EXEC_WAIT exits.
- Not defined: init_done = 1 from the first clock after reset deassertion; software performs init.

Decomposition:
- Package lcd_cmd_pkg holds:
  - the FSM state enum;
  - the LCD command constants CMD_CLEAR = 8'h01, CMD_HOME = 8'h02;
  - the init byte/nibble table and its wait constants.
- Sub-module lcd_cmd_fifo: synchronous FIFO of {rs, data[7:0]} with full, empty and level outputs. It shares ACLK/ARESETN.

Test Plan:
(Bench overrides SETUP_CYC=2, EN_HIGH_CYC=4, HOLD_CYC=1, NIB_GAP_CYC=3, EXEC_CYC=10, LONG_CYC=40; LCD_INIT_SEQ_EN undefined.)
- Single data byte: push rs=1, 0x41 -> lcd_d = 0x4 then 0x1, each with lcd_rs = 1 and lcd_en high exactly 4 cycles; busy high 27 cycles; fifo_level returns to 0.
- Clear command: push rs=0, 0x01 -> busy high 57 cycles; lcd_rs = 0 on both nibbles.
- Fill FIFO: 9 pushes while busy -> wr_ready = 0 after the 8th accepted push, fifo_level = 8. Bytes appear on lcd_d in push order with no loss.
- Push on the pop cycle with level 3 -> level stays 3. Check lcd_d/lcd_rs never change while lcd_en = 1.
- Assert ARESETN during EN_HI -> lcd_en = 0 asynchronously, fifo_level = 0, busy = 0, wr_ready = 1. The next push is transmitted normally.
- With LCD_INIT_SEQ_EN defined: after reset, init_done = 0 and the nibbles 3, 3, 3, 2 then bytes 28, 0C, 06, 01 appear. A byte pushed during init is emitted only after init_done = 1.
